// File: rtl/product_accum_pkg.sv
// Shared types and default widths for the product accumulator datapath.
package product_accum_pkg;

   // Control states of the accumulator burst FSM
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int DEF_PROD_WIDTH = 16;
   localparam int DEF_ACC_WIDTH  = 24;
   localparam int DEF_CNT_WIDTH  = 8;

endpackage

// File: rtl/product_accumulator_adder.sv
// Ripple carry adder: WIDTH-bit sum of a, b and cin with carry out.
module ripple_carry_adder #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   // One full adder per bit, carry rippling from LSB to MSB
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/product_accumulator.sv
// Burst multiply-accumulate stage: sums len unsigned products into a wrapping
// accumulator with a sticky overflow flag, handshaked on both sides.
module product_accumulator
   import product_accum_pkg::*;
#(
   parameter int PROD_WIDTH = DEF_PROD_WIDTH,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  len,
   output logic                  busy,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PROD_WIDTH-1:0] in_product,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_acc,
   output logic                  out_overflow
);

   state_e               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0] rem_q, rem_d;

   logic [ACC_WIDTH-1:0] add_b;
   logic [ACC_WIDTH-1:0] add_sum;
   logic                 add_cout;
   logic                 accept;

   // Products are unsigned, so widen with zeros before the add
   assign add_b  = ACC_WIDTH'(in_product);
   assign accept = (state_q == ACCUM) && in_valid;

   ripple_carry_adder #(
      .WIDTH (ACC_WIDTH)
   ) u_adder (
      .a    (acc_q),
      .b    (add_b),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // State register; reset aborts any burst in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic for the burst FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (accept && (rem_q == CNT_WIDTH'(1))) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state only
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE:    busy      = 1'b0;
         ACCUM:   in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: busy      = 1'b0;
      endcase
   end

   // Datapath next values: clear on start, add on each accepted product
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      rem_d = rem_q;
      if ((state_q == IDLE) && start) begin
         acc_d = '0;
         ovf_d = 1'b0;
         rem_d = len;
      end else if (accept) begin
         acc_d = add_sum;
         ovf_d = ovf_q | add_cout;
         rem_d = rem_q - CNT_WIDTH'(1);
      end
   end

   // Datapath registers; partial sums are discarded on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
         rem_q <= '0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
         rem_q <= rem_d;
      end
   end

   assign out_acc      = acc_q;
   assign out_overflow = ovf_q;

endmodule
